// File: rtl/morph_filter_1d_if.sv
`default_nettype none
// ============================================================================
// Module   : morph_filter_1d_if
// Purpose  : AXI-Stream style sample channel (tdata/tvalid/tready) used for
//            the input and output ports of morph_filter_1d.
// Revision : 1.0 - initial release
// ============================================================================
interface morph_filter_1d_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] tdata;
    logic                         tvalid;
    logic                         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/morph_filter_1d.sv
`default_nettype none
// ============================================================================
// Module   : morph_filter_1d
// Purpose  : 1-D grey-scale morphological filter. Dilation (max of x+h) or
//            erosion (min of x-h) over the last KERNEL_WIDTH samples, one tap
//            per clock, structuring element read from an external LUT.
// Revision : 1.0 - initial release
// ============================================================================
module morph_filter_1d #(
    parameter int DATA_WIDTH        = 16,
    parameter int KERNEL_WIDTH      = 71,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int INTERNAL_WIDTH    = 17
) (
    input  wire logic                                 clk,
    input  wire logic                                 areset_n,
    input  wire logic                                 mode,
    morph_filter_1d_if.slave                          axis_in,
    morph_filter_1d_if.master                         axis_out,
    output logic [$clog2(KERNEL_WIDTH)-1:0]           kernel_lut_address,
    input  wire logic signed [KERNEL_DATA_WIDTH-1:0]  kernel_lut_data,
    output logic                                      busy
);
    localparam int AW = $clog2(KERNEL_WIDTH);
    localparam int FW = $clog2(KERNEL_WIDTH + 1);
    localparam int DW = DATA_WIDTH;
    localparam int KW_BITS = KERNEL_DATA_WIDTH;
    localparam int IW = INTERNAL_WIDTH;

    localparam logic [FW-1:0] FILL_FULL = FW'(KERNEL_WIDTH);
    localparam logic [FW-1:0] LAST_TAP  = FW'(KERNEL_WIDTH - 1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(KERNEL_WIDTH - 1);
    localparam logic [AW-1:0] KW_MOD    = AW'(KERNEL_WIDTH);

    localparam logic signed [DW-1:0] DATA_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DATA_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [IW-1:0] SAT_MAX  = {{(IW-DW){DATA_MAX[DW-1]}}, DATA_MAX};
    localparam logic signed [IW-1:0] SAT_MIN  = {{(IW-DW){DATA_MIN[DW-1]}}, DATA_MIN};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREPARE = 2'd1,
        CALC    = 2'd2,
        FINAL   = 2'd3
    } state_t;

    state_t state, state_next;

    logic signed [DW-1:0] buffer [KERNEL_WIDTH];
    logic signed [DW-1:0] sample_q;
    logic [AW-1:0]        wr_ptr, cur_ptr, addr_tap, rd_idx;
    logic [FW-1:0]        fill, fill_lat, fill_inc, tap_cnt;
    logic                 mode_lat, accept, tap_included, last_tap;
    logic signed [DW-1:0] acc, acc_next, sat_val, out_data;
    logic signed [IW-1:0] x_ext, h_ext, sum;
    logic                 out_valid;

    assign accept         = axis_in.tvalid && (state == IDLE);
    assign axis_in.tready = (state == IDLE);
    assign axis_out.tvalid = out_valid;
    assign axis_out.tdata  = out_data;
    assign busy           = (state != IDLE);
    assign last_tap       = (tap_cnt == LAST_TAP);
    assign fill_inc       = (fill == FILL_FULL) ? fill : fill + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = PREPARE;
            PREPARE: state_next = CALC;
            CALC:    if (last_tap) state_next = FINAL;
            FINAL:   if (axis_out.tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tap address issued this cycle: tap 0 in PREPARE, tap c+1 in CALC cycle c
    always_comb begin
        addr_tap = '0;
        if (state == CALC) begin
            addr_tap = last_tap ? LAST_PTR : AW'(tap_cnt + 1'b1);
        end
        rd_idx = cur_ptr - addr_tap;
        if (cur_ptr < addr_tap) rd_idx = rd_idx + KW_MOD;
    end

    assign kernel_lut_address = addr_tap;

    // Sample storage (no reset: stale contents are masked by the fill count)
    always_ff @(posedge clk) begin
        if (accept) buffer[wr_ptr] <= axis_in.tdata;
        sample_q <= buffer[rd_idx];
    end

    // Per-tap saturating add/subtract and max/min fold
    always_comb begin
        x_ext = {{(IW-DW){sample_q[DW-1]}}, sample_q};
        h_ext = {{(IW-KW_BITS){kernel_lut_data[KW_BITS-1]}}, kernel_lut_data};
        sum   = mode_lat ? (x_ext - h_ext) : (x_ext + h_ext);
        if (sum > SAT_MAX)      sat_val = DATA_MAX;
        else if (sum < SAT_MIN) sat_val = DATA_MIN;
        else                    sat_val = sum[DW-1:0];
        tap_included = (tap_cnt < fill_lat);
        acc_next = acc;
        if (tap_included) begin
            if (mode_lat) begin
                if (sat_val < acc) acc_next = sat_val;
            end else begin
                if (sat_val > acc) acc_next = sat_val;
            end
        end
    end

    // Pointers, fill count, per-sample context, accumulator and output register
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            wr_ptr    <= '0;
            cur_ptr   <= '0;
            fill      <= '0;
            fill_lat  <= '0;
            mode_lat  <= 1'b0;
            tap_cnt   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                cur_ptr  <= wr_ptr;
                wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                fill     <= fill_inc;
                fill_lat <= fill_inc;
                mode_lat <= mode;
                tap_cnt  <= '0;
                acc      <= mode ? DATA_MAX : DATA_MIN;
            end
            if (state == CALC) begin
                tap_cnt <= tap_cnt + 1'b1;
                acc     <= acc_next;
                if (last_tap) begin
                    out_data  <= acc_next;
                    out_valid <= 1'b1;
                end
            end
            if (state == FINAL && axis_out.tready) out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_morph_filter_1d.sv
`default_nettype none
// ============================================================================
// Module   : tb_morph_filter_1d
// Purpose  : Directed, table-driven self-checking bench for morph_filter_1d
//            with KERNEL_WIDTH=4 and a registered kernel LUT model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morph_filter_1d;
    localparam int DW  = 16;
    localparam int KW  = 4;
    localparam int KDW = 8;
    localparam int IW  = 17;
    localparam int AW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  areset_n;
    logic                  mode;
    logic                  busy;
    logic [AW-1:0]         lut_addr;
    logic signed [KDW-1:0] lut_data;
    logic signed [KDW-1:0] h [KW];

    morph_filter_1d_if #(.DATA_WIDTH(DW)) axis_in ();
    morph_filter_1d_if #(.DATA_WIDTH(DW)) axis_out ();

    morph_filter_1d #(
        .DATA_WIDTH(DW), .KERNEL_WIDTH(KW),
        .KERNEL_DATA_WIDTH(KDW), .INTERNAL_WIDTH(IW)
    ) dut (
        .clk(clk), .areset_n(areset_n), .mode(mode),
        .axis_in(axis_in), .axis_out(axis_out),
        .kernel_lut_address(lut_addr), .kernel_lut_data(lut_data),
        .busy(busy)
    );

    // Registered kernel LUT: data for an address appears one cycle later
    always @(posedge clk) lut_data <= h[lut_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_kernel(input int k);
        case (k)
            1:       begin h[0] = 8'sd0;   h[1] = 8'sd1; h[2] = 8'sd2;    h[3] = 8'sd3;  end
            2:       begin h[0] = 8'sd127; h[1] = 8'sd0; h[2] = 8'sd0;    h[3] = 8'sd0;  end
            3:       begin h[0] = -8'sd5;  h[1] = 8'sd3; h[2] = -8'sd100; h[3] = 8'sd20; end
            default: begin h[0] = 8'sd0;   h[1] = 8'sd0; h[2] = 8'sd0;    h[3] = 8'sd0;  end
        endcase
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        areset_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    // One full transaction with out tready held high; checks latency and result
    task automatic send(input string name, input logic signed [15:0] x,
                        input logic m, input logic signed [15:0] exp);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 50 && !axis_in.tready; i++) @(negedge clk);
        chk({name, " in_ready"}, axis_in.tready, 1);
        axis_in.tdata  = x;
        axis_in.tvalid = 1'b1;
        mode           = m;
        @(posedge clk);
        #1 axis_in.tvalid = 1'b0;
        lat = 1;
        while (!axis_out.tvalid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, lat, 6);
        chk({name, " data"}, axis_out.tdata, exp);
        @(posedge clk);
        #1;
        chk({name, " valid_drop"}, axis_out.tvalid, 0);
        chk({name, " ready_back"}, axis_in.tready, 1);
    endtask

    typedef struct {
        bit                 rst;
        int                 kset;
        bit                 m;
        logic signed [15:0] x;
        logic signed [15:0] y;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_valid;
        int bp_bad;

        vecs[0]  = '{1'b1, 0, 1'b0, 16'sd5,      16'sd5};
        vecs[1]  = '{1'b0, 0, 1'b0, -16'sd3,     16'sd5};
        vecs[2]  = '{1'b0, 0, 1'b0, 16'sd7,      16'sd7};
        vecs[3]  = '{1'b0, 0, 1'b0, 16'sd2,      16'sd7};
        vecs[4]  = '{1'b0, 0, 1'b0, 16'sd1,      16'sd7};
        vecs[5]  = '{1'b1, 1, 1'b1, 16'sd10,     16'sd10};
        vecs[6]  = '{1'b0, 1, 1'b1, 16'sd10,     16'sd9};
        vecs[7]  = '{1'b0, 1, 1'b1, 16'sd10,     16'sd8};
        vecs[8]  = '{1'b0, 1, 1'b1, 16'sd10,     16'sd7};
        vecs[9]  = '{1'b1, 2, 1'b0, 16'sd32767,  16'sd32767};
        vecs[10] = '{1'b1, 2, 1'b1, -16'sd32768, -16'sd32768};
        vecs[11] = '{1'b1, 3, 1'b0, 16'sd100,    16'sd95};
        vecs[12] = '{1'b0, 3, 1'b0, 16'sd200,    16'sd195};
        vecs[13] = '{1'b0, 3, 1'b0, -16'sd50,    16'sd203};
        vecs[14] = '{1'b0, 3, 1'b1, 16'sd0,      -16'sd53};
        vecs[15] = '{1'b0, 3, 1'b1, 16'sd1,      -16'sd3};

        areset_n        = 1'b0;
        mode            = 1'b0;
        axis_in.tdata   = '0;
        axis_in.tvalid  = 1'b0;
        axis_out.tready = 1'b1;
        set_kernel(0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", axis_in.tready, 1);
        chk("rst out_valid", axis_out.tvalid, 0);
        chk("rst out_data", axis_out.tdata, 0);
        chk("rst busy", busy, 0);
        chk("rst lut_addr", lut_addr, 0);
        @(negedge clk);
        areset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset(2);
            set_kernel(vecs[i].kset);
            send($sformatf("vec%0d", i), vecs[i].x, vecs[i].m, vecs[i].y);
        end

        // Backpressure in FINAL with mode toggling during CALC
        do_reset(2);
        set_kernel(2);
        axis_out.tready = 1'b0;
        @(negedge clk);
        axis_in.tdata  = 16'sd42;
        axis_in.tvalid = 1'b1;
        mode           = 1'b0;
        @(posedge clk);
        #1 axis_in.tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mode = ~mode;
        end
        @(negedge clk);
        mode = 1'b1;
        for (int i = 0; i < 20 && !axis_out.tvalid; i++) @(negedge clk);
        chk("bp valid", axis_out.tvalid, 1);
        chk("bp data", axis_out.tdata, 169);
        bp_bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (axis_out.tvalid !== 1'b1 || axis_out.tdata !== 16'sd169 ||
                axis_in.tready !== 1'b0 || busy !== 1'b1) bp_bad++;
        end
        chk("bp hold", bp_bad, 0);
        @(negedge clk);
        axis_out.tready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp valid_drop", axis_out.tvalid, 0);
        chk("bp ready_back", axis_in.tready, 1);
        mode = 1'b0;

        // Reset during CALC: pending result dropped, history invalidated
        do_reset(2);
        set_kernel(0);
        send("pre1", 16'sd1, 1'b0, 16'sd1);
        send("pre2", 16'sd2, 1'b0, 16'sd2);
        send("pre3", 16'sd3, 1'b0, 16'sd3);
        @(negedge clk);
        axis_in.tdata  = 16'sd9;
        axis_in.tvalid = 1'b1;
        @(posedge clk);
        #1 axis_in.tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst busy", busy, 1);
        @(negedge clk);
        areset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        saw_valid = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (axis_out.tvalid !== 1'b0) saw_valid++;
        end
        chk("midrst no_stale", saw_valid, 0);
        chk("midrst in_ready", axis_in.tready, 1);
        send("post_rst", 16'sd4, 1'b0, 16'sd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/morph_filter_1d.md
MORPH_FILTER_1D -- requirements
Module: morph_filter_1d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed sample width.
REQ-002 SHALL have parameter KERNEL_WIDTH, default 71, number of taps (window length), minimum 2.
REQ-003 SHALL have parameter KERNEL_DATA_WIDTH, default 8, signed structuring-element value width.
REQ-004 SHALL have parameter INTERNAL_WIDTH, default 17, add width; must be greater than max(DATA_WIDTH, KERNEL_DATA_WIDTH).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port areset_n, input, 1, reset; reset is synchronous and active-low.
REQ-007 SHALL have port mode, input, 1, operation select: 0 = dilation, 1 = erosion.
REQ-008 SHALL have ports axis_in_tdata/tvalid/tready, in/in/out, DATA_WIDTH/1/1, input AXI-Stream sample.
REQ-009 SHALL have ports axis_out_tdata/tvalid/tready, out/out/in, DATA_WIDTH/1/1, output AXI-Stream result.
REQ-010 SHALL have port kernel_lut_address, output, $clog2(KERNEL_WIDTH), tap index to external kernel LUT.
REQ-011 SHALL have port kernel_lut_data, input, KERNEL_DATA_WIDTH signed, h[address], valid one cycle after the address is presented.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL hold the last KERNEL_WIDTH accepted samples in a circular buffer, with the write pointer wrapping from KERNEL_WIDTH-1 to 0.
REQ-014 SHALL use the read index (wr_ptr_at_accept - k) mod KERNEL_WIDTH for tap k, where x[n-0] is the newest sample.
REQ-015 SHALL keep a fill counter that increments per accepted sample and saturates at KERNEL_WIDTH.
REQ-016 SHALL include tap k only when k < fill count (counted including the current sample); excluded taps are skipped, not treated as zero.
REQ-017 SHALL, in dilation, output y = max over included k of sat(x[n-k] + h[k]).
REQ-018 SHALL, in erosion, output y = min over included k of sat(x[n-k] - h[k]).
REQ-019 SHALL sign-extend both operands to INTERNAL_WIDTH, form the sum, then saturate to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 SHALL initialise the accumulator to the DATA_WIDTH minimum for dilation and to the maximum for erosion.
REQ-021 SHALL sample mode only at input acceptance and latch it for that result; mode changes mid-calculation have no effect.
REQ-022 SHALL implement states IDLE, PREPARE, CALC and FINAL.
REQ-023 SHALL move IDLE->PREPARE on tvalid&&tready, PREPARE->CALC after 1 cycle, CALC->FINAL after exactly KERNEL_WIDTH cycles, and FINAL->IDLE on out tvalid&&tready.
REQ-024 SHALL drive axis_in_tready = (state == IDLE), combinationally.
REQ-025 SHALL write the sample to the buffer on the acceptance edge, so the current sample is readable from PREPARE onward.
REQ-026 SHALL issue buffer and LUT addresses for tap k in cycle k after entering PREPARE; each tap's operands arrive one cycle later.
REQ-027 SHALL assert axis_out_tvalid in the cycle the FSM enters FINAL, KERNEL_WIDTH+2 cycles after the acceptance edge.
REQ-028 SHALL keep tdata stable while tvalid=1 and tready=0.
REQ-029 SHALL deassert tvalid the cycle after handshake; the next input is accepted at the earliest one cycle later (throughput of one sample per KERNEL_WIDTH+3 cycles minimum).
REQ-030 SHALL drive kernel_lut_address to 0 when in IDLE.

Reset
REQ-031 SHALL, while areset_n=0 at a clock edge: state=IDLE, write pointer=0, fill count=0, axis_out_tvalid=0, axis_out_tdata=0, busy=0, latched mode=0.
REQ-032 SHALL hold axis_in_tready=1 after reset deassertion (IDLE).
REQ-033 SHALL, on reset mid-CALC or mid-FINAL, abandon the pending result without emitting it, and invalidate buffer contents via fill count=0 (RAM contents need not be cleared).

Verification (KERNEL_WIDTH=4, DATA_WIDTH=16, INTERNAL_WIDTH=17 unless stated)
REQ-034 SHALL verify reset: hold areset_n=0 for 3 cycles -> tready=1, tvalid=0, tdata=0, busy=0.
REQ-035 SHALL verify warm-up dilation: h={0,0,0,0}, mode=0, inputs 5,-3,7,2,1 -> outputs 5,5,7,7,7, each tvalid exactly 6 cycles after acceptance.
REQ-036 SHALL verify erosion with kernel: h={0,1,2,3}, mode=1, inputs 10,10,10,10 -> outputs 10,9,8,7.
REQ-037 SHALL verify saturation: h[0]=127, mode=0, input 32767 -> 32767; mode=1, input -32768 -> -32768.
REQ-038 SHALL verify backpressure plus mode latch: hold out tready=0 for 10 cycles in FINAL and toggle mode during CALC -> tvalid stays 1, tdata constant, in tready stays 0, result uses the accept-time mode.
REQ-039 SHALL verify reset mid-operation: after 3 inputs, reset during CALC, then input 4 with h=0 -> no stale output; first output is 4.
